// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into an instruction word by immsrc type,
// range-checks it, and streams the results through a 2-entry in-order output buffer.
module imm_encoder #(
    parameter int unsigned ERRW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     base_instr,
    input  logic [31:0]     imm,
    input  logic [2:0]      immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_err,
    output logic [ERRW-1:0] err_count
);

    localparam logic [2:0] SrcI = 3'b000;
    localparam logic [2:0] SrcS = 3'b001;
    localparam logic [2:0] SrcB = 3'b010;
    localparam logic [2:0] SrcJ = 3'b011;
    localparam logic [2:0] SrcU = 3'b100;

    // ------------------------------------------------------------------
    // Encoder (combinational, in front of the buffer)
    // ------------------------------------------------------------------
    logic        fits12;
    logic        fits13_even;
    logic        fits21_even;
    logic        low12_zero;
    logic [31:0] imm_bits;
    logic        enc_err;
    logic [31:0] enc_instr;

    // Sign-extension test: every bit above the field's sign bit must match it.
    assign fits12      = (imm[31:11] == {21{imm[11]}});
    assign fits13_even = (imm[31:12] == {20{imm[12]}}) && !imm[0];
    assign fits21_even = (imm[31:20] == {12{imm[20]}}) && !imm[0];
    assign low12_zero  = (imm[11:0] == 12'h000);

    always_comb begin
        imm_bits = 32'h0;
        enc_err  = 1'b0;
        case (immsrc)
            SrcI: begin
                imm_bits[31:20] = imm[11:0];
                enc_err         = !fits12;
            end
            SrcS: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                enc_err         = !fits12;
            end
            SrcB: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                enc_err         = !fits13_even;
            end
            SrcJ: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                enc_err         = !fits21_even;
            end
            SrcU: begin
                imm_bits[31:12] = imm[31:12];
                enc_err         = !low12_zero;
            end
            default: begin
                imm_bits = 32'h0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // An erroring word passes the base through untouched.
    assign enc_instr = enc_err ? base_instr : (base_instr | imm_bits);

    // ------------------------------------------------------------------
    // 2-entry output buffer: head slot drives the outputs directly
    // ------------------------------------------------------------------
    logic [1:0]      count_q, count_d;
    logic [31:0]     head_instr_q, head_instr_d;
    logic            head_err_q, head_err_d;
    logic [31:0]     tail_instr_q, tail_instr_d;
    logic            tail_err_q, tail_err_d;
    logic [ERRW-1:0] err_count_q, err_count_d;
    logic            push;
    logic            pop;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_err_d   = head_err_q;
        tail_instr_d = tail_instr_q;
        tail_err_d   = tail_err_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_instr_d = enc_instr;
                    head_err_d   = enc_err;
                    count_d      = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_instr_d = enc_instr;
                    head_err_d   = enc_err;
                end else if (push) begin
                    tail_instr_d = enc_instr;
                    tail_err_d   = enc_err;
                    count_d      = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_instr_d = tail_instr_q;
                    head_err_d   = tail_err_q;
                    count_d      = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_comb begin
        err_count_d = err_count_q;
        if (push && enc_err && (err_count_q != {ERRW{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= 2'd0;
            head_instr_q <= 32'h0;
            head_err_q   <= 1'b0;
            tail_instr_q <= 32'h0;
            tail_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_err_q   <= head_err_d;
            tail_instr_q <= tail_instr_d;
            tail_err_q   <= tail_err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_instr = head_instr_q;
    assign out_err   = head_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: encodings, range errors, backpressure ordering,
// async reset and error-counter saturation.
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base_instr;
    logic [31:0] imm;
    logic [2:0]  immsrc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    imm_encoder #(.ERRW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .base_instr (base_instr),
        .imm        (imm),
        .immsrc     (immsrc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word for a single edge, then drop in_valid just after that edge.
    task automatic send(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s);
        @(negedge clk);
        base_instr = b;
        imm        = i;
        immsrc     = s;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] ins, input logic err,
                               input logic [31:0] cnt);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, ins);
        check({tag, "_err"}, 32'(out_err), 32'(err));
        check({tag, "_cnt"}, 32'(err_count), cnt);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        base_instr = 32'h0;
        imm        = 32'h0;
        immsrc     = 3'b000;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_instr", out_instr, 32'h0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_cnt", 32'(err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic encodings, each one popped on the following edge.
        send(32'h0003_4313, 32'h0000_0001, 3'b000);
        expect_word("i_one", 32'h0013_4313, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        check("i_drain", 32'(out_valid), 32'd0);

        send(32'h0000_0387, 32'h0000_3000, 3'b100);
        expect_word("u_ok", 32'h0000_3387, 1'b0, 32'd0);
        send(32'h0000_0387, 32'h0000_3001, 3'b100);
        expect_word("u_err", 32'h0000_0387, 1'b1, 32'd1);
        send(32'h0000_006F, 32'hFFFF_FFFC, 3'b011);
        expect_word("j_neg4", 32'hFFDF_F06F, 1'b0, 32'd1);
        send(32'h0000_0063, 32'hFFFF_FFF8, 3'b010);
        expect_word("b_neg8", 32'hFE00_0CE3, 1'b0, 32'd1);
        send(32'h0000_0023, 32'h0000_0025, 3'b001);
        expect_word("s_37", 32'h0200_02A3, 1'b0, 32'd1);

        // Range boundaries.
        send(32'h0000_0013, 32'h0000_07FF, 3'b000);
        expect_word("i_max", 32'h7FF0_0013, 1'b0, 32'd1);
        send(32'h0000_0013, 32'hFFFF_F800, 3'b000);
        expect_word("i_min", 32'h8000_0013, 1'b0, 32'd1);
        send(32'h0003_4313, 32'h0000_0800, 3'b000);
        expect_word("i_2048", 32'h0003_4313, 1'b1, 32'd2);
        send(32'h0003_4313, 32'h0000_0001, 3'b111);
        expect_word("illegal", 32'h0003_4313, 1'b1, 32'd3);
        send(32'h0000_0063, 32'h0000_0FFE, 3'b010);
        expect_word("b_max", 32'h7E00_0FE3, 1'b0, 32'd3);
        send(32'h0000_0063, 32'h0000_0003, 3'b010);
        expect_word("b_odd", 32'h0000_0063, 1'b1, 32'd4);
        send(32'h0000_006F, 32'h0010_0000, 3'b011);
        expect_word("j_over", 32'h0000_006F, 1'b1, 32'd5);
        @(posedge clk);
        #1;

        // Backpressure: fill both slots, third word must wait, order preserved.
        @(negedge clk);
        out_ready  = 1'b0;
        base_instr = 32'h0000_0013;
        immsrc     = 3'b000;
        imm        = 32'd1;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready1", 32'(in_ready), 32'd1);
        check("bp_head1", out_instr, 32'h0010_0013);
        @(negedge clk);
        imm = 32'd2;
        @(posedge clk);
        #1;
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_head2", out_instr, 32'h0010_0013);
        @(negedge clk);
        imm = 32'd3;
        @(posedge clk);
        #1;
        check("bp_hold_rdy", 32'(in_ready), 32'd0);
        check("bp_hold", out_instr, 32'h0010_0013);
        check("bp_hold_v", 32'(out_valid), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_pop1", out_instr, 32'h0020_0013);
        check("bp_rdy_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_third", out_instr, 32'h0030_0013);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_empty", 32'(out_valid), 32'd0);

        // Async reset with a full buffer.
        @(negedge clk);
        out_ready = 1'b0;
        send(32'h0000_0387, 32'h0000_0001, 3'b100);
        send(32'h0000_0387, 32'h0000_0002, 3'b100);
        check("pre_rst_rdy", 32'(in_ready), 32'd0);
        check("pre_rst_cnt", 32'(err_count), 32'd7);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_cnt", 32'(err_count), 32'd0);
        check("arst_instr", out_instr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Saturation: 300 erroring words streamed back-to-back.
        out_ready  = 1'b1;
        base_instr = 32'h0;
        immsrc     = 3'b111;
        in_valid   = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("sat_cnt", 32'(err_count), 32'd255);
        check("sat_err", 32'(out_err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
